// File: rtl/pulse_cmd_regfile.sv
// Host-command register bank: assembles UART byte frames, writes or reads parameter registers, and answers over UART.
// Optional build macro PCMD_READBACK_EN adds the register read path and the multi-byte read response.
module pulse_cmd_regfile #(
    parameter int                         NUM_REGS    = 8,
    parameter int                         DATA_W      = 32,
    parameter logic [NUM_REGS*DATA_W-1:0] INIT        = '0,
    parameter logic [31:0]                TIMEOUT_CYC = 32'd2010000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       rx_valid,
    input  logic [7:0]                 rx_byte,
    input  logic                       tx_busy,
    output logic                       tx_start,
    output logic [7:0]                 tx_byte,
    output logic [NUM_REGS*DATA_W-1:0] regs_flat,
    output logic [NUM_REGS-1:0]        upd,
    output logic [7:0]                 err_cnt,
    output logic                       busy
);

    // state   | meaning
    // S_RX    | collecting payload bytes, then the control byte
    // S_EXEC  | executing the command, loading the response buffer
    // S_TX    | waiting for the UART to go idle, then issuing tx_start
    // S_TXARM | one-cycle gap covering the UART busy-flag latency

    localparam int DATA_BYTES = (DATA_W + 7) / 8;
    localparam int PAY_W      = DATA_BYTES * 8;
    localparam int CNT_W      = 4;

    typedef enum logic [1:0] {S_RX, S_EXEC, S_TX, S_TXARM} state_t;

    state_t             state;
    state_t             state_nxt;

    logic               rx_valid_q;
    logic               rx_edge;
    logic [CNT_W-1:0]   byte_cnt;
    logic [PAY_W-1:0]   payload;
    logic [7:0]         ctrl;
    logic [31:0]        idle_cnt;
    logic [PAY_W-1:0]   resp_buf;
    logic [CNT_W-1:0]   resp_cnt;
    logic [DATA_W-1:0]  regs [NUM_REGS];

    logic               byte_take;
    logic               ctrl_take;
    logic               timeout_fire;
    logic               is_read;
    logic               idx_ok;
    logic               do_write;
    logic               exec_err;
    logic               err_evt;
    logic [7:0]         csum;
    logic [PAY_W-1:0]   resp_word;
    logic [CNT_W-1:0]   resp_len;

    assign rx_edge   = rx_valid & ~rx_valid_q;
    assign byte_take = rx_edge && (state == S_RX);
    assign ctrl_take = byte_take && (byte_cnt == CNT_W'(DATA_BYTES));
    assign is_read   = ctrl[7];
    assign idx_ok    = ({1'b0, ctrl[6:0]} < 8'(NUM_REGS));
    assign do_write  = (state == S_EXEC) && !is_read && idx_ok;
    assign tx_byte   = resp_buf[7:0];

    // A byte landing on the terminal-count cycle wins over the timeout.
    assign timeout_fire = (TIMEOUT_CYC != 32'd0) && (state == S_RX) && (byte_cnt != '0)
                          && !rx_edge && (idle_cnt == 32'd1);

    assign err_evt = (rx_edge && (state != S_RX)) || ((state == S_EXEC) && exec_err) || timeout_fire;

    always_comb begin
        csum = '0;
        for (int i = 0; i < DATA_BYTES; i++) begin
            csum = csum + payload[8*i +: 8];
        end
    end

    always_comb begin
        resp_word = '0;
        resp_len  = CNT_W'(1);
        exec_err  = 1'b0;
`ifdef PCMD_READBACK_EN
        if (is_read) begin
            if (idx_ok) begin
                for (int k = 0; k < NUM_REGS; k++) begin
                    if (ctrl[6:0] == 7'(k)) begin
                        resp_word[DATA_W-1:0] = regs[k];
                    end
                end
                resp_len = CNT_W'(DATA_BYTES);
            end else begin
                resp_word[7:0] = 8'hEE;
                exec_err       = 1'b1;
            end
        end else if (idx_ok) begin
            resp_word[7:0] = csum;
        end else begin
            resp_word[7:0] = ~csum;
            exec_err       = 1'b1;
        end
`else
        // Without readback a read frame is a harmless no-op that echoes the checksum.
        if (is_read || idx_ok) begin
            resp_word[7:0] = csum;
        end else begin
            resp_word[7:0] = ~csum;
            exec_err       = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_RX;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        tx_start  = 1'b0;
        busy      = (state != S_RX);
        case (state)
            S_RX: begin
                if (ctrl_take) begin
                    state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                state_nxt = S_TX;
            end
            S_TX: begin
                if (!tx_busy) begin
                    tx_start  = 1'b1;
                    state_nxt = S_TXARM;
                end
            end
            S_TXARM: begin
                state_nxt = (resp_cnt > CNT_W'(1)) ? S_TX : S_RX;
            end
            default: begin
                state_nxt = S_RX;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_valid_q <= 1'b0;
            byte_cnt   <= '0;
            payload    <= '0;
            ctrl       <= '0;
            idle_cnt   <= '0;
            resp_buf   <= '0;
            resp_cnt   <= '0;
            err_cnt    <= '0;
        end else begin
            rx_valid_q <= rx_valid;
            if (err_evt && (err_cnt != 8'hFF)) begin
                err_cnt <= err_cnt + 8'd1;
            end
            case (state)
                S_RX: begin
                    if (byte_take) begin
                        if (ctrl_take) begin
                            ctrl     <= rx_byte;
                            idle_cnt <= '0;
                        end else begin
                            payload  <= (payload >> 8) | (PAY_W'(rx_byte) << (PAY_W - 8));
                            byte_cnt <= byte_cnt + CNT_W'(1);
                            idle_cnt <= TIMEOUT_CYC;
                        end
                    end else if (timeout_fire) begin
                        byte_cnt <= '0;
                        idle_cnt <= '0;
                    end else if (idle_cnt != 32'd0) begin
                        idle_cnt <= idle_cnt - 32'd1;
                    end
                end
                S_EXEC: begin
                    resp_buf <= resp_word;
                    resp_cnt <= resp_len;
                end
                S_TXARM: begin
                    resp_buf <= resp_buf >> 8;
                    resp_cnt <= resp_cnt - CNT_W'(1);
                    if (resp_cnt <= CNT_W'(1)) begin
                        byte_cnt <= '0;
                        idle_cnt <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            upd <= '0;
            for (int k = 0; k < NUM_REGS; k++) begin
                regs[k] <= INIT[k*DATA_W +: DATA_W];
            end
        end else begin
            upd <= '0;
            if (do_write) begin
                for (int k = 0; k < NUM_REGS; k++) begin
                    if (ctrl[6:0] == 7'(k)) begin
                        regs[k] <= payload[DATA_W-1:0];
                        upd[k]  <= 1'b1;
                    end
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign regs_flat[g*DATA_W +: DATA_W] = regs[g];
    end

endmodule
